// File: rtl/alu_ram_seq.sv
// Single-operation sequencer for the RAM/ALU datapath: two operand reads,
// one ALU evaluation, one write-back, with a fixed five-cycle busy window.
module alu_ram_seq #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        op,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_d,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              zero,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [4:0]        alu_op,
    input  logic [31:0]       alu_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        LATCH = 3'd3,
        EXEC  = 3'd4,
        WB    = 3'd5
    } state_t;

    state_t            state;
    logic [4:0]        op_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [ADDR_W-1:0] addr_d_q;

    // The write-back word is the captured result; it holds between operations.
    assign wr_data = result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            addr_b_q <= '0;
            addr_d_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        addr_b_q <= addr_b;
                        addr_d_q <= addr_d;
                        rd_addr  <= addr_a;
                        busy     <= 1'b1;
                        state    <= RD_A;
                    end
                end
                RD_A: begin
                    rd_addr <= addr_b_q;
                    state   <= RD_B;
                end
                RD_B: begin
                    alu_a <= rd_data;
                    state <= LATCH;
                end
                LATCH: begin
                    alu_b  <= rd_data;
                    alu_op <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    // Both reads are done, so a destination aliasing an operand is safe.
                    result  <= alu_out;
                    zero    <= (alu_out == 32'd0);
                    wr_en   <= 1'b1;
                    wr_addr <= addr_d_q;
                    done    <= 1'b1;
                    state   <= WB;
                end
                WB: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
